// File: rtl/logic_unit_pipe_if.sv
// Stream bundle for logic_unit_pipe: operand beat in, result beat out, debug count.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; parity present only with LOGIC_UNIT_PIPE_PARITY_EN.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [2:0]       op_out;
   logic [CNT_W-1:0] done_cnt;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic             parity;
`endif

   // Producer and consumer side of the block.
   modport master (
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
      input  parity,
`endif
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, op_out, done_cnt
   );

   // The pipe itself.
   modport slave (
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
      output parity,
`endif
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, op_out, done_cnt
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR/PASS) with done counter and zero flag.
// Latency: 2 cycles from acceptance to result; 1 beat/cycle throughput.
// Backpressure: holds 2 beats when out_ready=0; optional parity output via LOGIC_UNIT_PIPE_PARITY_EN.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic           core_clk,
   input  logic           rst,
   logic_unit_pipe_if.slave bus
);
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_zero;
   logic [2:0]       s2_op;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_res;
   logic             s1_load;
   logic             s2_load;
   logic             in_rdy;
   logic             handoff;

   // Stage advance: S2 takes S1 whenever S2 is empty or draining; S1 frees up when it moves.
   assign s2_load = s1_valid && (!s2_valid || bus.out_ready);
   assign in_rdy  = !s1_valid || s2_load;
   assign s1_load = bus.in_valid && in_rdy;
   assign handoff = s2_valid && bus.out_ready;

   // Bitwise operation on the S1 registers; b unused for NOT and PASS.
   always_comb begin
      op_res = s1_a;
      case (s1_op)
         3'd0:    op_res = s1_a & s1_b;
         3'd1:    op_res = s1_a | s1_b;
         3'd2:    op_res = ~s1_a;
         3'd3:    op_res = ~(s1_a & s1_b);
         3'd4:    op_res = ~(s1_a | s1_b);
         3'd5:    op_res = s1_a ^ s1_b;
         3'd6:    op_res = ~(s1_a ^ s1_b);
         default: op_res = s1_a;
      endcase
   end

   // Stage 1 valid and operand capture.
   always_ff @(posedge core_clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= 3'd0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= bus.op;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2 result registers; held stable while stalled.
   always_ff @(posedge core_clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_zero   <= 1'b1;
         s2_op     <= 3'd0;
      end else begin
         if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= op_res;
            s2_zero   <= (op_res == '0);
            s2_op     <= s1_op;
         end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
         end
      end
   end

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic s2_parity;

   // Parity of the result, captured alongside it.
   always_ff @(posedge core_clk) begin
      if (rst) begin
         s2_parity <= 1'b0;
      end else if (s2_load) begin
         s2_parity <= ^op_res;
      end
   end

   assign bus.parity = s2_parity;
`endif

   // Completed-result counter, free-running wrap.
   always_ff @(posedge core_clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (handoff) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = s2_valid;
   assign bus.result    = s2_result;
   assign bus.zero      = s2_zero;
   assign bus.op_out    = s2_op;
   assign bus.done_cnt  = cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4 so the counter wrap is reachable).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A negedge monitor logs every acceptance and every handoff for in-order checks.
module tb_logic_unit_pipe;
   logic core_clk = 1'b0;
   logic rst      = 1'b1;
   int   total    = 0;
   int   bad      = 0;
   int   cyc      = 0;

   logic [7:0] got_res[$];
   logic       got_zero[$];
   logic [2:0] got_op[$];
   logic       got_par[$];
   int         got_cyc[$];
   int         acc_cyc[$];

   logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut (
      .core_clk (core_clk),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 core_clk = ~core_clk;

   always @(posedge core_clk) cyc <= cyc + 1;

   always @(negedge core_clk) begin
      if (!rst && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (!rst && bus.out_valid && bus.out_ready) begin
         got_res.push_back(bus.result);
         got_zero.push_back(bus.zero);
         got_op.push_back(bus.op_out);
         got_cyc.push_back(cyc);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
         got_par.push_back(bus.parity);
`endif
      end
   end

   task automatic clear_logs();
      got_res.delete(); got_zero.delete(); got_op.delete();
      got_par.delete(); got_cyc.delete(); acc_cyc.delete();
   endtask

   task automatic do_reset(input int n);
      @(posedge core_clk); #1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (n) @(posedge core_clk);
      #1;
      rst = 1'b0;
      clear_logs();
   endtask

   // Present one beat and hold it until it is accepted; returns 1ns after the accepting edge.
   task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] ov);
      int t;
      bus.in_valid = 1'b1;
      bus.a = av; bus.b = bv; bus.op = ov;
      t = 0;
      @(negedge core_clk);
      while (!bus.in_ready && t < 50) begin
         @(negedge core_clk);
         t++;
      end
      total++;
      if (!bus.in_ready) begin
         bad++;
         $display("FAIL send_accept in_ready=%0b required=1 after %0d cycles", bus.in_ready, t);
      end
      @(posedge core_clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      int t;
      t = 0;
      while (got_res.size() < n && t < 200) begin
         @(negedge core_clk);
         t++;
      end
      repeat (3) @(negedge core_clk);
      total++;
      if (got_res.size() != n) begin
         bad++;
         $display("FAIL drain_count got=%0d required=%0d", got_res.size(), n);
      end
      @(posedge core_clk); #1;
   endtask

   task automatic test_reset();
      do_reset(2);
      @(negedge core_clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", bus.out_valid); end
      total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h required=00", bus.result); end
      total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%0b required=1", bus.zero); end
      total++; if (bus.op_out !== 3'd0) begin bad++; $display("FAIL reset_op_out got=%0d required=0", bus.op_out); end
      total++; if (bus.done_cnt !== 4'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d required=0", bus.done_cnt); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready); end
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
      total++; if (bus.parity !== 1'b0) begin bad++; $display("FAIL reset_parity got=%0b required=0", bus.parity); end
`endif
      @(posedge core_clk); #1;
   endtask

   task automatic test_all_ops();
      logic [7:0] exp_res [8];
      exp_res = '{8'h24, 8'hBD, 8'h5A, 8'hDB, 8'h42, 8'h99, 8'h66, 8'hA5};
      do_reset(1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(8'hA5, 8'h3C, 3'(i));
      drain(8);
      for (int i = 0; i < 8 && i < got_res.size(); i++) begin
         total++; if (got_res[i] !== exp_res[i]) begin bad++; $display("FAIL ops_result[%0d] got=%h required=%h", i, got_res[i], exp_res[i]); end
         total++; if (got_op[i] !== 3'(i)) begin bad++; $display("FAIL ops_op_out[%0d] got=%0d required=%0d", i, got_op[i], i); end
         total++; if (got_zero[i] !== 1'b0) begin bad++; $display("FAIL ops_zero[%0d] got=%0b required=0", i, got_zero[i]); end
         total++; if (got_cyc[i] - acc_cyc[i] != 2) begin bad++; $display("FAIL ops_latency[%0d] got=%0d required=2", i, got_cyc[i] - acc_cyc[i]); end
         total++; if (got_cyc[i] != got_cyc[0] + i) begin bad++; $display("FAIL ops_back_to_back[%0d] got=%0d required=%0d", i, got_cyc[i] - got_cyc[0], i); end
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
         total++; if (got_par[i] !== 1'b0) begin bad++; $display("FAIL ops_parity[%0d] got=%0b required=0", i, got_par[i]); end
`endif
      end
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd8) begin bad++; $display("FAIL ops_done_cnt got=%0d required=8", bus.done_cnt); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ops_idle_out_valid got=%0b required=0", bus.out_valid); end
      @(posedge core_clk); #1;
   endtask

   task automatic test_zero_flag();
      logic [7:0] exp_res [4];
      logic       exp_z   [4];
      logic       exp_p   [4];
      exp_res = '{8'h00, 8'h00, 8'hFF, 8'h01};
      exp_z   = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_p   = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset(1);
      bus.out_ready = 1'b1;
      send(8'hFF, 8'hFF, 3'd5);
      send(8'hFF, 8'hFF, 3'd4);
      send(8'hFF, 8'hFF, 3'd1);
      send(8'h01, 8'hF0, 3'd7);
      drain(4);
      for (int i = 0; i < 4 && i < got_res.size(); i++) begin
         total++; if (got_res[i] !== exp_res[i]) begin bad++; $display("FAIL zero_result[%0d] got=%h required=%h", i, got_res[i], exp_res[i]); end
         total++; if (got_zero[i] !== exp_z[i]) begin bad++; $display("FAIL zero_flag[%0d] got=%0b required=%0b", i, got_zero[i], exp_z[i]); end
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
         total++; if (got_par[i] !== exp_p[i]) begin bad++; $display("FAIL zero_parity[%0d] got=%0b required=%0b", i, got_par[i], exp_p[i]); end
`else
         if (exp_p[i] === 1'bx) $display("unexpected table entry");
`endif
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_res [5];
      logic [7:0] held;
      exp_res = '{8'h10, 8'h36, 8'h26, 8'hFF, 8'h00};
      do_reset(1);
      bus.out_ready = 1'b0;
      fork
         begin
            send(8'h12, 8'h34, 3'd0);
            send(8'h12, 8'h34, 3'd1);
            send(8'h12, 8'h34, 3'd5);
            send(8'hF0, 8'h0F, 3'd3);
            send(8'hF0, 8'h0F, 3'd6);
         end
         begin
            repeat (2) @(posedge core_clk);
            @(negedge core_clk);
            total++; if (acc_cyc.size() != 2) begin bad++; $display("FAIL bp_accepted got=%0d required=2", acc_cyc.size()); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b required=0", bus.in_ready); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%0b required=1", bus.out_valid); end
            total++; if (bus.result !== 8'h10) begin bad++; $display("FAIL bp_head_result got=%h required=10", bus.result); end
            held = bus.result;
            repeat (2) begin
               @(negedge core_clk);
               total++; if (bus.result !== held) begin bad++; $display("FAIL bp_stable got=%h required=%h", bus.result, held); end
               total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_hold got=%0b required=0", bus.in_ready); end
            end
            @(posedge core_clk); #1;
            bus.out_ready = 1'b1;
            @(negedge core_clk);
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_in_ready got=%0b required=1", bus.in_ready); end
         end
      join
      drain(5);
      for (int i = 0; i < 5 && i < got_res.size(); i++) begin
         total++; if (got_res[i] !== exp_res[i]) begin bad++; $display("FAIL bp_result[%0d] got=%h required=%h", i, got_res[i], exp_res[i]); end
      end
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd5) begin bad++; $display("FAIL bp_done_cnt got=%0d required=5", bus.done_cnt); end
      @(posedge core_clk); #1;
   endtask

   task automatic test_counter_wrap();
      do_reset(1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) send(8'h0F, 8'h33, 3'(i % 8));
      drain(15);
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d required=15", bus.done_cnt); end
      @(posedge core_clk); #1;
      send(8'h01, 8'h02, 3'd1);
      drain(16);
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d required=0", bus.done_cnt); end
      @(posedge core_clk); #1;
      send(8'h01, 8'h02, 3'd1);
      drain(17);
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd1) begin bad++; $display("FAIL wrap_1 got=%0d required=1", bus.done_cnt); end
      @(posedge core_clk); #1;
   endtask

   task automatic test_mid_reset();
      do_reset(1);
      bus.out_ready = 1'b1;
      send(8'h55, 8'hAA, 3'd1);
      drain(1);
      @(negedge core_clk);
      total++; if (bus.done_cnt !== 4'd1) begin bad++; $display("FAIL mrst_pre_cnt got=%0d required=1", bus.done_cnt); end
      @(posedge core_clk); #1;
      bus.out_ready = 1'b0;
      send(8'h11, 8'h22, 3'd1);
      send(8'h33, 8'h44, 3'd5);
      rst = 1'b1;
      @(posedge core_clk); #1;
      rst = 1'b0;
      clear_logs();
      @(negedge core_clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%0b required=0", bus.out_valid); end
      total++; if (bus.done_cnt !== 4'd0) begin bad++; $display("FAIL mrst_done_cnt got=%0d required=0", bus.done_cnt); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%0b required=1", bus.in_ready); end
      @(posedge core_clk); #1;
      bus.out_ready = 1'b1;
      repeat (5) @(negedge core_clk);
      total++; if (got_res.size() != 0) begin bad++; $display("FAIL mrst_stale got=%0d required=0", got_res.size()); end
      total++; if (bus.done_cnt !== 4'd0) begin bad++; $display("FAIL mrst_cnt_after got=%0d required=0", bus.done_cnt); end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = 8'h00;
      bus.b         = 8'h00;
      bus.op        = 3'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_all_ops();
      test_zero_flag();
      test_backpressure();
      test_counter_wrap();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
